// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-window convolution over a raster pixel stream, with runtime
// weights/bias, ReLU, saturation and ready/valid flow control on both sides.
module conv3x3_stream #(
   parameter int DATA_W = 8,
   parameter int FRAC   = 4,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [3:0]               cfg_addr,
   input  logic signed [DATA_W-1:0] cfg_data,
   input  logic                     relu_en,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] pixel_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_last,
   output logic                     busy
);
   localparam int ACC_W = 2*DATA_W + 5;
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   logic [CW-1:0]              col;
   logic [RW-1:0]              row;
   logic signed [DATA_W-1:0]   lb0 [IMG_W];
   logic signed [DATA_W-1:0]   lb1 [IMG_W];
   logic signed [DATA_W-1:0]   win [9];
   logic signed [DATA_W-1:0]   wgt [9];
   logic signed [DATA_W-1:0]   bias;
   logic                       win_valid;
   logic                       win_last;
   logic                       en;
   logic                       accept;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    shifted;
   logic signed [DATA_W-1:0]   res;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign accept   = in_valid && en;
   assign busy     = (row != '0) || (col != '0) || win_valid || out_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 9; i++) wgt[i] <= '0;
         bias <= '0;
      end else if (cfg_we && !busy) begin
         for (int i = 0; i < 9; i++)
            if (cfg_addr == 4'(i)) wgt[i] <= cfg_data;
         if (cfg_addr == 4'd9) bias <= cfg_data;
      end
   end

   // win[0..2] is the oldest row, win[6..8] the row of the accepted pixel
   always_comb begin
      prod = '0;
      acc  = ACC_W'(bias) <<< FRAC;
      for (int i = 0; i < 9; i++) begin
         prod = wgt[i] * win[i];
         acc  = acc + ACC_W'(prod);
      end
      shifted = acc >>> FRAC;
      if (relu_en && shifted[ACC_W-1])
         res = '0;
      else if (shifted > SAT_MAX)
         res = DATA_W'(SAT_MAX);
      else if (shifted < SAT_MIN)
         res = DATA_W'(SAT_MIN);
      else
         res = DATA_W'(shifted);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col       <= '0;
         row       <= '0;
         win_valid <= 1'b0;
         win_last  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         for (int i = 0; i < 9; i++) win[i] <= '0;
         for (int i = 0; i < IMG_W; i++) begin
            lb0[i] <= '0;
            lb1[i] <= '0;
         end
      end else if (en) begin
         out_valid <= win_valid;
         out_last  <= win_valid && win_last;
         if (win_valid) out_data <= res;
         win_valid <= accept && (row >= RW'(2)) && (col >= CW'(2));
         win_last  <= accept && (row == ROW_LAST) && (col == COL_LAST);
         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               win[3*r]   <= win[3*r+1];
               win[3*r+1] <= win[3*r+2];
            end
            win[2]   <= lb1[col];
            win[5]   <= lb0[col];
            win[8]   <= pixel_in;
            lb1[col] <= lb0[col];
            lb0[col] <= pixel_in;
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on a 4x4 image: kernels, saturation, ReLU,
// bias, backpressure, gapped back-to-back frames, busy-gated config and reset.
module tb_conv3x3_stream;
   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_we;
   logic [3:0]        cfg_addr;
   logic signed [7:0] cfg_data;
   logic              relu_en;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] pixel_in;
   logic              out_valid;
   logic              out_ready;
   logic signed [7:0] out_data;
   logic              out_last;
   logic              busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic signed [7:0] pix [16];
   int acc_cyc [16];
   int q_data [$];
   int q_last [$];
   int q_cyc  [$];
   int exp_q  [$];

   conv3x3_stream #(.DATA_W(8), .FRAC(4), .IMG_W(4), .IMG_H(4)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // an output transfer happens on the next rising edge when both are high mid-cycle
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         q_data.push_back(int'(out_data));
         q_last.push_back(int'(out_last));
         q_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int addr, input int data);
      cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_data = 8'(data);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic set_kernel(input int center, input int others, input int b);
      for (int i = 0; i < 9; i++) cfg_write(i, (i == 4) ? center : others);
      cfg_write(9, b);
   endtask

   task automatic send_px(input logic signed [7:0] v, output int ac);
      bit got;
      int n;
      got = 1'b0; n = 0;
      in_valid = 1'b1; pixel_in = v;
      while (!got && n < 200) begin
         @(negedge clk);
         got = in_ready;
         tick();
         n++;
      end
      in_valid = 1'b0;
      if (!got) chk("in_timeout", 0, 1);
      ac = cyc;
   endtask

   task automatic send_range(input int lo, input int hi, input int gap);
      for (int i = lo; i <= hi; i++) begin
         send_px(pix[i], acc_cyc[i]);
         if (gap > 0 && (i % 3) == 2) repeat (gap) tick();
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, int'(busy), 0);
      tick();
   endtask

   task automatic check_outs(input string tag);
      chk({tag, "_count"}, q_data.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < q_data.size(); k++) begin
         chk($sformatf("%s_data%0d", tag, k), q_data[k], exp_q[k]);
         chk($sformatf("%s_last%0d", tag, k), q_last[k], ((k % 4) == 3) ? 1 : 0);
      end
      q_data.delete(); q_last.delete(); q_cyc.delete();
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < 16; i++) pix[i] = 8'(i);
   endtask

   task automatic fill_const(input int v);
      for (int i = 0; i < 16; i++) pix[i] = 8'(v);
   endtask

   initial begin
      int lowc;
      int held;
      int n;
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; relu_en = 1'b0;
      in_valid = 1'b0; pixel_in = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_busy", int'(busy), 0);
      tick();

      // identity kernel on a ramp, plus one-cycle latency per window
      set_kernel(16, 0, 0);
      fill_ramp();
      send_range(0, 15, 0);
      drain("ident");
      if (q_cyc.size() == 4) begin
         chk("lat_10", q_cyc[0], acc_cyc[10] + 1);
         chk("lat_11", q_cyc[1], acc_cyc[11] + 1);
         chk("lat_14", q_cyc[2], acc_cyc[14] + 1);
         chk("lat_15", q_cyc[3], acc_cyc[15] + 1);
      end else chk("lat_count", q_cyc.size(), 4);
      exp_q = '{5, 6, 9, 10};
      check_outs("ident");

      set_kernel(16, 16, 0);
      fill_const(16);
      send_range(0, 15, 0);
      drain("satpos");
      exp_q = '{127, 127, 127, 127};
      check_outs("satpos");

      set_kernel(-16, -16, 0);
      send_range(0, 15, 0);
      drain("satneg");
      exp_q = '{-128, -128, -128, -128};
      check_outs("satneg");

      relu_en = 1'b1;
      send_range(0, 15, 0);
      drain("relu");
      exp_q = '{0, 0, 0, 0};
      check_outs("relu");
      relu_en = 1'b0;

      set_kernel(16, 0, 8);
      send_range(0, 15, 0);
      drain("biaspos");
      exp_q = '{24, 24, 24, 24};
      check_outs("biaspos");

      set_kernel(16, 0, -32);
      send_range(0, 15, 0);
      drain("biasneg");
      exp_q = '{-16, -16, -16, -16};
      check_outs("biasneg");

      // stall the output for three cycles while the stream is still running
      set_kernel(16, 0, 0);
      fill_ramp();
      fork
         send_range(0, 15, 0);
         begin
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 200) begin
               @(negedge clk);
               n++;
            end
            chk("stall_seen_valid", int'(out_valid), 1);
            tick();
            out_ready = 1'b0;
            lowc = 0;
            held = 0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               if (k == 0) held = int'(out_data);
               else chk($sformatf("stall_hold%0d", k), int'(out_data), held);
               chk($sformatf("stall_valid%0d", k), int'(out_valid), 1);
               if (!in_ready) lowc++;
               tick();
            end
            out_ready = 1'b1;
            chk("stall_in_ready_low", lowc, 3);
         end
      join
      drain("stall");
      exp_q = '{5, 6, 9, 10};
      check_outs("stall");

      send_range(0, 15, 2);
      send_range(0, 15, 2);
      drain("b2b");
      exp_q = '{5, 6, 9, 10, 5, 6, 9, 10};
      check_outs("b2b");

      // mid-frame weight write must be dropped
      send_range(0, 5, 0);
      @(negedge clk);
      chk("busy_mid", int'(busy), 1);
      tick();
      cfg_write(4, 32);
      send_range(6, 15, 0);
      drain("busywr");
      exp_q = '{5, 6, 9, 10};
      check_outs("busywr");

      send_range(0, 5, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_out_valid", int'(out_valid), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_in_ready", int'(in_ready), 1);
      tick();
      rst = 1'b0;
      tick();
      send_range(0, 15, 0);
      drain("mrst_zero");
      exp_q = '{0, 0, 0, 0};
      check_outs("mrst_zero");

      set_kernel(16, 0, 0);
      send_range(0, 15, 0);
      drain("mrst_fresh");
      exp_q = '{5, 6, 9, 10};
      check_outs("mrst_fresh");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
